// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes a mnemonic index plus register/immediate
// fields into a 32-bit MIPS instruction word. Encoded words are buffered in a
// DEPTH-entry FIFO and streamed out with auto-incrementing instruction-memory
// addresses, starting at BASE_ADDR after reset.
//
// Optional feature: define ENC_FIELD_CHECK_EN to reject a legal mnemonic that
// carries a nonzero value in any field it does not use. Without the macro,
// unused fields are forced to zero and only indices 29..31 are rejected.
module instr_encoder_loader #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_mnem,
    input  logic [4:0]                 in_rs,
    input  logic [4:0]                 in_rt,
    input  logic [4:0]                 in_rd,
    input  logic [15:0]                in_imm,
    input  logic [25:0]                in_target,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [31:0]                out_addr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;

    logic [11:0]   opfn_s;
    logic [1:0]    fmt_s;
    logic          use_rs_s, use_rt_s, use_rd_s, use_imm_s, use_tgt_s;
    logic          illegal_s;
    logic          reject_s;
    logic [31:0]   enc_word_s;
    logic          push_s, pop_s;
    logic [CW-1:0] count_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [31:0]   head_nxt_s;

    logic [31:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   out_data_r, out_addr_r;
    logic          out_valid_r, in_ready_r, err_r;

    // Opcode and funct lookup for each mnemonic index.
    always_comb begin
        opfn_s = {6'h00, 6'h00};
        case (in_mnem)
            5'd0:    opfn_s = {6'h00, 6'h20};
            5'd1:    opfn_s = {6'h00, 6'h22};
            5'd2:    opfn_s = {6'h00, 6'h24};
            5'd3:    opfn_s = {6'h00, 6'h25};
            5'd4:    opfn_s = {6'h00, 6'h2A};
            5'd5:    opfn_s = {6'h00, 6'h2B};
            5'd6:    opfn_s = {6'h0D, 6'h00};
            5'd7:    opfn_s = {6'h08, 6'h00};
            5'd8:    opfn_s = {6'h0C, 6'h00};
            5'd9:    opfn_s = {6'h23, 6'h00};
            5'd10:   opfn_s = {6'h21, 6'h00};
            5'd11:   opfn_s = {6'h20, 6'h00};
            5'd12:   opfn_s = {6'h2B, 6'h00};
            5'd13:   opfn_s = {6'h29, 6'h00};
            5'd14:   opfn_s = {6'h28, 6'h00};
            5'd15:   opfn_s = {6'h04, 6'h00};
            5'd16:   opfn_s = {6'h05, 6'h00};
            5'd17:   opfn_s = {6'h0F, 6'h00};
            5'd18:   opfn_s = {6'h02, 6'h00};
            5'd19:   opfn_s = {6'h03, 6'h00};
            5'd20:   opfn_s = {6'h00, 6'h08};
            5'd21:   opfn_s = {6'h00, 6'h18};
            5'd22:   opfn_s = {6'h00, 6'h19};
            5'd23:   opfn_s = {6'h00, 6'h1A};
            5'd24:   opfn_s = {6'h00, 6'h1B};
            5'd25:   opfn_s = {6'h00, 6'h12};
            5'd26:   opfn_s = {6'h00, 6'h10};
            5'd27:   opfn_s = {6'h00, 6'h13};
            5'd28:   opfn_s = {6'h00, 6'h11};
            default: opfn_s = {6'h00, 6'h00};
        endcase
    end

    // Instruction format and which input fields each mnemonic group consumes.
    always_comb begin
        fmt_s     = FMT_R;
        use_rs_s  = 1'b0;
        use_rt_s  = 1'b0;
        use_rd_s  = 1'b0;
        use_imm_s = 1'b0;
        use_tgt_s = 1'b0;
        illegal_s = 1'b0;
        case (in_mnem)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5: begin
                use_rs_s = 1'b1; use_rt_s = 1'b1; use_rd_s = 1'b1;
            end
            5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16: begin
                fmt_s = FMT_I; use_rs_s = 1'b1; use_rt_s = 1'b1; use_imm_s = 1'b1;
            end
            5'd17: begin
                fmt_s = FMT_I; use_rt_s = 1'b1; use_imm_s = 1'b1;
            end
            5'd18, 5'd19: begin
                fmt_s = FMT_J; use_tgt_s = 1'b1;
            end
            5'd20, 5'd27, 5'd28: begin
                use_rs_s = 1'b1;
            end
            5'd21, 5'd22, 5'd23, 5'd24: begin
                use_rs_s = 1'b1; use_rt_s = 1'b1;
            end
            5'd25, 5'd26: begin
                use_rd_s = 1'b1;
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Assemble the word from masked fields so unused fields always encode as zero.
    always_comb begin
        logic [4:0]  rs_m, rt_m, rd_m;
        logic [15:0] imm_m;
        logic [25:0] tgt_m;
        rs_m  = use_rs_s  ? in_rs     : 5'd0;
        rt_m  = use_rt_s  ? in_rt     : 5'd0;
        rd_m  = use_rd_s  ? in_rd     : 5'd0;
        imm_m = use_imm_s ? in_imm    : 16'd0;
        tgt_m = use_tgt_s ? in_target : 26'd0;
        case (fmt_s)
            FMT_R:   enc_word_s = {opfn_s[11:6], rs_m, rt_m, rd_m, 5'd0, opfn_s[5:0]};
            FMT_I:   enc_word_s = {opfn_s[11:6], rs_m, rt_m, imm_m};
            FMT_J:   enc_word_s = {opfn_s[11:6], tgt_m};
            default: enc_word_s = 32'd0;
        endcase
    end

`ifdef ENC_FIELD_CHECK_EN
    // Reject illegal indices and legal mnemonics carrying junk in unused fields.
    always_comb begin
        reject_s = illegal_s
                 | (!use_rs_s  && (in_rs     != 5'd0))
                 | (!use_rt_s  && (in_rt     != 5'd0))
                 | (!use_rd_s  && (in_rd     != 5'd0))
                 | (!use_imm_s && (in_imm    != 16'd0))
                 | (!use_tgt_s && (in_target != 26'd0));
    end
`else
    // Reject only illegal mnemonic indices; unused fields are masked off.
    always_comb begin
        reject_s = illegal_s;
    end
`endif

    // FIFO handshake, next occupancy and next head word.
    always_comb begin
        push_s       = in_valid & in_ready_r & ~reject_s;
        pop_s        = out_valid_r & out_ready;
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        // The new head is the incoming word when it lands exactly at the head slot.
        if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_nxt_s = enc_word_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= enc_word_s;
        end
    end

    // Pointers, occupancy, registered outputs and the error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            err_r       <= 1'b0;
            out_addr_r  <= BASE_ADDR;
            out_data_r  <= 32'd0;
        end else begin
            wr_ptr_r    <= push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != '0);
            in_ready_r  <= (count_nxt_s < DEPTH_C);
            err_r       <= in_valid & in_ready_r & reject_s;
            out_addr_r  <= pop_s ? (out_addr_r + 32'd4) : out_addr_r;
            if (count_nxt_s != '0) begin
                out_data_r <= head_nxt_s;
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_addr  = out_addr_r;
    assign count     = count_r;
    assign err       = err_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios plus randomized traffic,
// checked cycle by cycle against a queue-based reference model that encodes
// words from the opcode/funct tables with plain arithmetic.
module tb_instr_encoder_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_3000;

    logic        clk, reset, in_valid, in_ready, out_valid, out_ready, err;
    logic [4:0]  in_mnem, in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic [31:0] out_data, out_addr;
    logic [$clog2(DEPTH):0] count;

    instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .count(count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tables
    int r_fn  [6]  = '{32, 34, 36, 37, 42, 43};
    int i_op  [11] = '{13, 8, 12, 35, 33, 32, 43, 41, 40, 4, 5};
    int md_fn [4]  = '{24, 25, 26, 27};

    // Directed sequence: ori, lui, jal, jr, mfhi
    int          seq_m   [5] = '{6, 17, 19, 20, 26};
    int          seq_rs  [5] = '{0, 0, 0, 31, 0};
    int          seq_rt  [5] = '{1, 2, 0, 0, 0};
    int          seq_rd  [5] = '{0, 0, 0, 0, 4};
    int          seq_imm [5] = '{32'h1234, 32'hFFFF, 0, 0, 0};
    int          seq_tgt [5] = '{0, 0, 32'hC00, 0, 0};
    logic [31:0] seq_exp [5] = '{32'h34011234, 32'h3C02FFFF, 32'h0C000C00, 32'h03E00008, 32'h00002010};

    // Model state
    logic [31:0] q [$];
    logic [31:0] m_addr, m_last;
    bit          m_err;
    logic [31:0] plog [$];
    logic [31:0] alog [$];
    int n_total = 0;
    int n_bad   = 0;
    int n_junk  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference encoder: bad = illegal index, fbad = nonzero unused field.
    function automatic void ref_enc(input int m, input int rs, input int rt, input int rd,
                                    input int imm, input int tgt,
                                    output logic [31:0] w, output bit bad, output bit fbad);
        longint v;
        bit urs, urt, urd, uimm, utgt;
        v = 0; bad = 0; urs = 0; urt = 0; urd = 0; uimm = 0; utgt = 0;
        if (m <= 5) begin
            v = rs * 2**21 + rt * 2**16 + rd * 2**11 + r_fn[m];
            urs = 1; urt = 1; urd = 1;
        end else if (m <= 16) begin
            v = longint'(i_op[m-6]) * 2**26 + rs * 2**21 + rt * 2**16 + imm;
            urs = 1; urt = 1; uimm = 1;
        end else if (m == 17) begin
            v = longint'(15) * 2**26 + rt * 2**16 + imm;
            urt = 1; uimm = 1;
        end else if (m == 18 || m == 19) begin
            v = longint'(m - 16) * 2**26 + tgt;
            utgt = 1;
        end else if (m == 20) begin
            v = rs * 2**21 + 8;
            urs = 1;
        end else if (m <= 24) begin
            v = rs * 2**21 + rt * 2**16 + md_fn[m-21];
            urs = 1; urt = 1;
        end else if (m == 25 || m == 26) begin
            v = rd * 2**11 + ((m == 25) ? 18 : 16);
            urd = 1;
        end else if (m == 27 || m == 28) begin
            v = rs * 2**21 + ((m == 27) ? 19 : 17);
            urs = 1;
        end else begin
            bad = 1;
        end
        fbad = !bad && ((!urs && rs != 0) || (!urt && rt != 0) || (!urd && rd != 0) ||
                        (!uimm && imm != 0) || (!utgt && tgt != 0));
        w = v[31:0];
    endfunction

    // One clock: predict, advance, then compare every output with the model.
    task automatic cycle();
        bit acc, pop, bad, fbad;
        logic [31:0] w;
        acc = in_valid && (q.size() < DEPTH);
        pop = out_ready && (q.size() != 0);
        ref_enc(int'(in_mnem), int'(in_rs), int'(in_rt), int'(in_rd),
                int'(in_imm), int'(in_target), w, bad, fbad);
`ifdef ENC_FIELD_CHECK_EN
        bad = bad | fbad;
`endif
        if (acc && !bad && fbad) n_junk++;
        if (pop && !reset) begin
            plog.push_back(out_data);
            alog.push_back(out_addr);
        end
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            m_addr = BASE; m_last = 32'd0; m_err = 0;
        end else begin
            if (pop) begin
                q.delete(0);
                m_addr = m_addr + 32'd4;
            end
            if (acc && !bad) q.push_back(w);
            m_err = acc && bad;
        end
        if (q.size() != 0) m_last = q[0];
        chk("count",     32'(count),     32'(q.size()));
        chk("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_data",  out_data,       m_last);
        chk("out_addr",  out_addr,       m_addr);
        chk("err",       32'(err),       32'(m_err));
    endtask

    task automatic req(input int m, input int rs, input int rt, input int rd, input int imm, input int tgt);
        in_valid = 1'b1; in_mnem = 5'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = 16'(imm); in_target = 26'(tgt);
    endtask

    task automatic idle();
        in_valid = 1'b0; in_mnem = 5'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
        in_imm = 16'd0; in_target = 26'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1; idle(); cycle(); reset = 1'b0;
    endtask

    initial begin
        int tries;
        q.delete(); m_addr = BASE; m_last = 32'd0; m_err = 0;
        idle(); out_ready = 1'b0; reset = 1'b1;
        cycle(); cycle();
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_addr", out_addr, 32'h0000_3000);
        chk("rst_data", out_data, 32'd0);
        cycle();

        // add rd=3 rs=1 rt=2
        req(0, 1, 2, 3, 0, 0); cycle(); idle();
        chk("tp1_valid", 32'(out_valid), 32'd1);
        chk("tp1_data", out_data, 32'h00221820);
        chk("tp1_addr", out_addr, 32'h00003000);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
        chk("tp1_addr_inc", out_addr, 32'h00003004);

        // Five requests into a 4-deep FIFO with the consumer stalled
        do_reset(); plog.delete(); alog.delete(); out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req(seq_m[i], seq_rs[i], seq_rt[i], seq_rd[i], seq_imm[i], seq_tgt[i]);
            tries = 0;
            while (q.size() >= DEPTH && tries < 20) begin
                if (tries < 2) begin
                    chk("tp2_full_ready", 32'(in_ready), 32'd0);
                    chk("tp2_full_count", 32'(count), 32'd4);
                end
                if (tries == 2) out_ready = 1'b1;
                cycle(); tries++;
            end
            cycle();
        end
        idle(); out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) cycle();
        chk("tp2_npop", 32'(plog.size()), 32'd5);
        for (int i = 0; i < 5 && i < plog.size(); i++) begin
            chk("tp2_word", plog[i], seq_exp[i]);
            chk("tp2_addr", alog[i], BASE + 32'(4 * i));
        end

        // Illegal index
        do_reset(); out_ready = 1'b0;
        req(29, 1, 2, 3, 4, 5); cycle(); idle();
        chk("tp3_err", 32'(err), 32'd1);
        chk("tp3_count", 32'(count), 32'd0);
        chk("tp3_valid", 32'(out_valid), 32'd0);
        cycle();
        chk("tp3_err_clr", 32'(err), 32'd0);

        // Simultaneous push and pop at count=2, then reset mid-stream
        do_reset(); plog.delete(); alog.delete(); out_ready = 1'b0;
        req(0, 1, 2, 3, 0, 0); cycle();
        req(1, 4, 5, 6, 0, 0); cycle();
        out_ready = 1'b1;
        req(7, 7, 8, 0, 16'h00AB, 0); cycle();
        chk("tp4_count_a", 32'(count), 32'd2);
        req(12, 9, 10, 0, 16'hFFFC, 0); cycle();
        chk("tp4_count_b", 32'(count), 32'd2);
        idle();
        for (int i = 0; i < 6; i++) cycle();
        chk("tp4_npop", 32'(plog.size()), 32'd4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin req(2, i, i + 1, i + 2, 0, 0); cycle(); end
        chk("tp4_pre_rst", 32'(count), 32'd3);
        do_reset();
        chk("tp4_rst_count", 32'(count), 32'd0);
        chk("tp4_rst_valid", 32'(out_valid), 32'd0);
        req(3, 1, 1, 1, 0, 0); cycle(); idle();
        chk("tp4_rst_addr", out_addr, 32'h00003000);
        out_ready = 1'b1; cycle();

        // add with a nonzero immediate (unused field)
        do_reset(); out_ready = 1'b0;
        req(0, 1, 2, 3, 1, 0); cycle(); idle();
`ifdef ENC_FIELD_CHECK_EN
        chk("tp5_err", 32'(err), 32'd1);
        chk("tp5_count", 32'(count), 32'd0);
`else
        chk("tp5_err", 32'(err), 32'd0);
        chk("tp5_data", out_data, 32'h00221820);
`endif
        out_ready = 1'b1; cycle(); cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                if ($urandom_range(0, 1) == 1)
                    req($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                        $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 67108863));
                else
                    req($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 0, 0, 0);
            end else begin
                idle();
            end
            out_ready = ($urandom_range(0, 9) < 6);
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0; idle();
        cycle();

        $display("junk-field requests accepted: %0d", n_junk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart of the pipeline's instruction decoder: converts a mnemonic index plus register and immediate fields into a 32-bit MIPS word.
- Buffers encoded words in a small FIFO and streams them out with auto-incrementing instruction-memory addresses.
- Used by the testbench and boot-loader path to fill instruction memory, and to round-trip-check the decoder.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- BASE_ADDR, 32'h0000_3000, address paired with the first word popped after reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  encode request present
- in_ready  output  1  request accepted this cycle when in_valid & in_ready
- in_mnem  input  5  mnemonic index (table below)
- in_rs  input  5  rs field
- in_rt  input  5  rt field
- in_rd  input  5  rd field
- in_imm  input  16  immediate / offset
- in_target  input  26  jump target (j/jal)
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer takes head when out_valid & out_ready
- out_data  output  32  encoded word at head
- out_addr  output  32  instruction-memory address of head
- count  output  $clog2(DEPTH)+1  current FIFO occupancy
- err  output  1  one-cycle pulse: accepted request rejected

Behaviour:
- Mnemonic index table:
  - 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sltu
  - 6 ori, 7 addi, 8 andi
  - 9 lw, 10 lh, 11 lb, 12 sw, 13 sh, 14 sb
  - 15 beq, 16 bne, 17 lui, 18 j, 19 jal, 20 jr
  - 21 mult, 22 multu, 23 div, 24 divu
  - 25 mflo, 26 mfhi, 27 mtlo, 28 mthi
  - 29..31 illegal
- Opcodes: ori 0x0D, addi 0x08, andi 0x0C, lw 0x23, lh 0x21, lb 0x20, sw 0x2B, sh 0x29, sb 0x28, beq 0x04, bne 0x05, lui 0x0F, j 0x02, jal 0x03. All other mnemonics use opcode 0x00.
- Funct codes: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sltu 0x2B, jr 0x08, mult 0x18, multu 0x19, div 0x1A, divu 0x1B, mflo 0x12, mfhi 0x10, mtlo 0x13, mthi 0x11.
- Field use; every unused field is forced to 0:
  - R-ALU (0..5): rs, rt, rd, shamt=0, funct
  - mult/multu/div/divu: rs, rt
  - mflo/mfhi: rd
  - mtlo/mthi/jr: rs
  - I-type (6..16): {op, rs, rt, imm}
  - lui: {op, 0, rt, imm}
  - j/jal: {op, target}
- Encoding is combinational from the inputs. On an accepted legal request the word is written at the tail on the same clock edge, so out_valid rises the next cycle (1-cycle latency).
- in_ready = (count < DEPTH). It stays low when full even if a pop occurs that cycle; there is no full-bypass.
- Illegal index when accepted: nothing enqueued; err = 1 for one cycle on the following cycle; count unchanged.
- Pop on out_valid & out_ready: head pointer advances and out_addr increments by 4.
- out_addr wraps modulo 2^32 with no flag.
- Push and pop in the same cycle on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- Empty: out_valid = 0 and out_data holds its last value. The consumer must ignore out_data when out_valid = 0.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Reset values:
  - count = 0, pointers = 0, out_valid = 0
  - in_ready = 1 in the first cycle after reset is deasserted
  - err = 0, out_addr = BASE_ADDR, out_data = 0
- Reset mid-stream discards all buffered words and restarts addressing at BASE_ADDR.

Optional Feature:
- Macro: ENC_FIELD_CHECK_EN.
- Defined: a legal mnemonic with a nonzero value in any field it does not use is rejected. Example: add with in_imm != 0, or lui with in_rs != 0. Rejection behaves exactly like an illegal index (err pulse, no enqueue).
- Undefined: unused fields are silently forced to 0 and err fires only for indices 29..31.

Test Plan:
- add rd=3 rs=1 rt=2 -> one cycle later out_valid=1, out_data=0x00221820, out_addr=0x00003000; pop -> out_addr=0x00003004.
- Sequence ori rt=1 rs=0 imm=0x1234; lui rt=2 imm=0xFFFF; jal target=0x0000C00; jr rs=31; mfhi rd=4 -> popped words 0x34011234, 0x3C02FFFF, 0x0C000C00, 0x03E00008, 0x00002010 at addresses 0x3000..0x3010.
- out_ready=0, five back-to-back requests (DEPTH=4) -> in_ready low after the 4th accept, count=4, 5th held. Raise out_ready -> 5th accepted, order preserved, all five pop in order.
- in_mnem=29 accepted -> err high exactly one cycle, count stays 0, out_valid stays 0.
- Simultaneous push/pop with count=2 -> count stays 2 and data order is intact. Assert reset with 3 entries buffered -> count=0, out_valid=0, next popped word has out_addr=0x00003000.
- With ENC_FIELD_CHECK_EN: add with imm=1 -> err pulse, not enqueued. Without the macro: same request -> 0x00221820 enqueued, err stays 0.
